// File: rtl/cacheline_arbiter_if.sv
// Cache-side and pmem-side signals of the cacheline arbiter.
// master = caches plus memory model; slave = the arbiter itself.
interface cacheline_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic               pmem_read;
  logic               pmem_write;
  logic [ADDR_W-1:0]  pmem_address;
  logic [BURST_W-1:0] pmem_wdata;
  logic [BURST_W-1:0] pmem_rdata;
  logic               pmem_resp;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates I/D cache line transfers onto one burst pmem port; CACHELINE_ARB_RR_EN enables alternating tie-break.
// Latency: grant + BEATS + 1 cycles at zero wait; pmem_resp low stalls the burst, other requests wait.
module cacheline_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input logic                clk,
  input logic                rst,
  cacheline_arbiter_if.slave bus
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] addr_q;
  logic              owner_d;
  logic              rd_q;
  logic              wr_q;
  logic              i_resp_q;
  logic              d_resp_q;

  logic d_req;
  logic grant_d;
  logic grant_i;

  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHELINE_ARB_RR_EN
  // Tracks the winner of the last contended grant only, so uncontended traffic does not skew the alternation.
  logic last_d;
  assign grant_d = d_req & (~bus.i_read | ~last_d);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = bus.i_read & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
      owner_d  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
`ifdef CACHELINE_ARB_RR_EN
      last_d   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef CACHELINE_ARB_RR_EN
          if (d_req && bus.i_read)
            last_d <= grant_d;
`endif
          if (grant_d) begin
            owner_d <= 1'b1;
            addr_q  <= bus.d_address & LINE_MASK;
            // A simultaneous read+write is treated as a writeback.
            if (bus.d_write) begin
              line_buf <= bus.d_wdata;
              wr_q     <= 1'b1;
              state    <= D_WR;
            end else begin
              rd_q  <= 1'b1;
              state <= D_RD;
            end
          end else if (grant_i) begin
            owner_d <= 1'b0;
            addr_q  <= bus.i_address & LINE_MASK;
            rd_q    <= 1'b1;
            state   <= I_RD;
          end
        end

        I_RD, D_RD, D_WR: begin
          if (bus.pmem_resp) begin
            if (state != D_WR)
              line_buf[cnt*BURST_W +: BURST_W] <= bus.pmem_rdata;
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              rd_q  <= 1'b0;
              wr_q  <= 1'b0;
              state <= DONE;
              if (owner_d) d_resp_q <= 1'b1;
              else         i_resp_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = line_buf[cnt*BURST_W +: BURST_W];
  assign bus.i_rdata      = line_buf;
  assign bus.d_rdata      = line_buf;
  assign bus.i_resp       = i_resp_q;
  assign bus.d_resp       = d_resp_q;

endmodule
